// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: operation and state types plus decode helpers shared by the sequential ALU.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_BLT  = 4'd12,
    OP_BGE  = 4'd13,
    OP_BLTU = 4'd14,
    OP_BGEU = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic op_is_shift(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic op_is_branch(input alu_op_t op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
           (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// alu_seq_shifter: iterative shifter, SHIFT_STEP bits per cycle while the remaining count allows, else 1.
// Latency: floor(s/SHIFT_STEP) + (s mod SHIFT_STEP) enabled cycles after load.
// Backpressure: none; the owner gates progress with enable.
// Ports: load (capture value/count/mode), enable (advance one step), dir_right/arith (mode, sampled
//        on load), load_val/load_cnt, shifted (accumulator value after this cycle's step),
//        last (this step brings the count to zero).
module alu_seq_shifter
  import alu_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      load,
  input  logic                      enable,
  input  logic                      dir_right,
  input  logic                      arith,
  input  logic [XLEN-1:0]           load_val,
  input  logic [$clog2(XLEN)-1:0]   load_cnt,
  output logic [XLEN-1:0]           shifted,
  output logic                      last
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] STEP_CNT = SHW'(SHIFT_STEP);

  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            right_q, right_d;
  logic            arith_q, arith_d;

  logic            big_step;
  logic [SHW-1:0]  dec;
  logic            fill;
  logic [XLEN-1:0] by_one, by_step;

  always_comb begin
    big_step = (cnt_q >= STEP_CNT);
    dec      = big_step ? STEP_CNT : SHW'(1);
    // Sign fill only for arithmetic right shifts; logical shifts bring in zeros.
    fill     = arith_q & acc_q[XLEN-1];
    if (right_q) begin
      by_one  = {fill, acc_q[XLEN-1:1]};
      by_step = {{SHIFT_STEP{fill}}, acc_q[XLEN-1:SHIFT_STEP]};
    end else begin
      by_one  = {acc_q[XLEN-2:0], 1'b0};
      by_step = {acc_q[XLEN-1-SHIFT_STEP:0], {SHIFT_STEP{1'b0}}};
    end
    shifted = big_step ? by_step : by_one;
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    arith_d = arith_q;
    last    = 1'b0;
    if (load) begin
      acc_d   = load_val;
      cnt_d   = load_cnt;
      right_d = dir_right;
      arith_d = arith;
    end else if (enable) begin
      acc_d = shifted;
      cnt_d = cnt_q - dec;
      last  = (cnt_q == dec);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU (add/sub, logic, set-less-than, iterative shifts, branch compares).
// Latency: 1 cycle after accept; shifts with s>0 take 1 + floor(s/SHIFT_STEP) + s mod SHIFT_STEP.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush aborts to IDLE.
// Ports: clk/rstn, flush, in_valid/in_ready + op/op1/op2, out_valid/out_ready + result/cmp/carry.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            cmp,
  output logic            carry
);

  localparam int SHW = $clog2(XLEN);

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            cmp_q, cmp_d;
  logic            carry_q, carry_d;

  alu_op_t         op_e;
  logic [SHW-1:0]  sh_amt;
  logic            sh_load, sh_en, sh_last;
  logic [XLEN-1:0] sh_val;

  logic [XLEN:0]   sum_w, diff_w;
  logic            lt_s, lt_u, eq;
  logic            br_taken;
  logic [XLEN-1:0] alu_res;
  logic            alu_carry, alu_cmp;

  assign op_e   = alu_op_t'(op);
  assign sh_amt = op2[SHW-1:0];

  // Combinational arith/logic/compare unit, evaluated on the offered operands in IDLE.
  always_comb begin
    sum_w     = {1'b0, op1} + {1'b0, op2};
    diff_w    = {1'b0, op1} + {1'b0, ~op2} + {{XLEN{1'b0}}, 1'b1};
    lt_s      = $signed(op1) < $signed(op2);
    lt_u      = op1 < op2;
    eq        = (op1 == op2);
    alu_res   = '0;
    alu_carry = 1'b0;
    br_taken  = 1'b0;
    case (op_e)
      OP_ADD:  begin alu_res = sum_w[XLEN-1:0];  alu_carry = sum_w[XLEN];  end
      OP_SUB:  begin alu_res = diff_w[XLEN-1:0]; alu_carry = diff_w[XLEN]; end
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      // Only reached with a zero shift amount; non-zero amounts go through the shifter.
      OP_SLL, OP_SRL, OP_SRA: alu_res = op1;
      OP_BEQ:  br_taken = eq;
      OP_BNE:  br_taken = !eq;
      OP_BLT:  br_taken = lt_s;
      OP_BGE:  br_taken = !lt_s;
      OP_BLTU: br_taken = lt_u;
      OP_BGEU: br_taken = !lt_u;
      default: alu_res = '0;
    endcase
    alu_cmp = op_is_branch(op_e) & br_taken;
  end

  alu_seq_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .load      (sh_load),
    .enable    (sh_en),
    .dir_right (op_e != OP_SLL),
    .arith     (op_e == OP_SRA),
    .load_val  (op1),
    .load_cnt  (sh_amt),
    .shifted   (sh_val),
    .last      (sh_last)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cmp_d    = cmp_q;
    carry_d  = carry_q;
    sh_load  = 1'b0;
    sh_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op_is_shift(op_e) && (sh_amt != '0)) begin
            sh_load = 1'b1;
            cmp_d   = 1'b0;
            carry_d = 1'b0;
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_res;
            cmp_d    = alu_cmp;
            carry_d  = alu_carry;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        sh_en = 1'b1;
        if (sh_last) begin
          result_d = sh_val;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // flush wins over every transition, including an accept in the same cycle.
    if (flush) begin
      state_d = ST_IDLE;
      sh_load = 1'b0;
      sh_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      cmp_q    <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cmp_q    <= cmp_d;
      carry_q  <= carry_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cmp       = cmp_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a behavioural model.
// Latency: model predicts cycles from accept to out_valid.
// Backpressure: random out_ready hold with junk in_valid offered while busy.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        in_ready, out_valid, cmp, carry;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  alu_seq #(.XLEN(32), .SHIFT_STEP(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cmp       (cmp),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: {cmp, carry, result} from the operation rules.
  function automatic logic [33:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c, y;
    logic [63:0] sum;
    int          s;
    r = 32'd0; c = 1'b0; y = 1'b0;
    s = int'(b[4:0]);
    sum = 64'(a) + 64'(b);
    case (o)
      OP_ADD:  begin r = sum[31:0]; y = sum[32]; end
      OP_SUB:  begin r = a - b; y = (a >= b); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  r = a << s;
      OP_SRL:  r = a >> s;
      OP_SRA:  r = $unsigned($signed(a) >>> s);
      OP_BEQ:  c = (a == b);
      OP_BNE:  c = (a != b);
      OP_BLT:  c = ($signed(a) < $signed(b));
      OP_BGE:  c = ($signed(a) >= $signed(b));
      OP_BLTU: c = (a < b);
      OP_BGEU: c = (a >= b);
      default: r = 32'd0;
    endcase
    return {c, y, r};
  endfunction

  function automatic int exp_lat(input logic [3:0] o, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    if ((o == OP_SLL || o == OP_SRL || o == OP_SRA) && s > 0)
      return 1 + s / 4 + s % 4;
    return 1;
  endfunction

  // Offer one operation once the block is idle; returns just after the accept edge.
  task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("launch_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [31:0] r, output logic c, output logic y, output int lat);
    logic [33:0] e;
    e = model(o, a, b);
    launch(o, a, b);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check("latency", 64'(lat), 64'(exp_lat(o, b)));
    check("result", 64'(result), 64'(e[31:0]));
    check("carry", 64'(carry), 64'(e[32]));
    check("cmp", 64'(cmp), 64'(e[33]));
    check("busy_in_ready", 64'(in_ready), 64'd0);
    r = result; y = carry; c = cmp;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 4'($urandom); op1 = $urandom; op2 = $urandom;
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_result", 64'(result), 64'(e[31:0]));
      check("hold_flags", 64'({cmp, carry}), 64'(e[33:32]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("ret_in_ready", 64'(in_ready), 64'd1);
    check("ret_out_valid", 64'(out_valid), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    logic        c, y;
    int          lat, seen;

    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({cmp, carry}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 0, r, c, y, lat);
    check("add_wrap_res", 64'(r), 64'd0);
    check("add_wrap_carry", 64'(y), 64'd1);
    check("add_wrap_lat", 64'(lat), 64'd1);

    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, 0, r, c, y, lat);
    check("slt_res", 64'(r), 64'd1);
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 0, r, c, y, lat);
    check("sltu_res", 64'(r), 64'd0);
    run_op(OP_BLTU, 32'hFFFF_FFFF, 32'h1, 0, r, c, y, lat);
    check("bltu_cmp", 64'(c), 64'd0);
    check("bltu_res", 64'(r), 64'd0);
    run_op(OP_BLT, 32'hFFFF_FFFF, 32'h1, 0, r, c, y, lat);
    check("blt_cmp", 64'(c), 64'd1);

    run_op(OP_SRA, 32'h8000_0000, 32'd7, 0, r, c, y, lat);
    check("sra7_res", 64'(r), 64'hFF00_0000);
    check("sra7_lat", 64'(lat), 64'd5);
    run_op(OP_SLL, 32'h1, 32'd0, 0, r, c, y, lat);
    check("sll0_res", 64'(r), 64'd1);
    check("sll0_lat", 64'(lat), 64'd1);
    run_op(OP_SRL, 32'hF000_0000, 32'd31, 1, r, c, y, lat);
    check("srl31_lat", 64'(lat), 64'd11);

    // Backpressure: three cycles without out_ready while junk is offered.
    run_op(OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 3, r, c, y, lat);

    // Flush during the second SHIFT cycle of a long shift, with a competing offer.
    launch(OP_SRL, 32'hDEAD_BEEF, 32'd31);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1; op = OP_ADD; op1 = 32'd9; op2 = 32'd9;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    run_op(OP_ADD, 32'd2, 32'd3, 0, r, c, y, lat);
    check("post_flush_add", 64'(r), 64'd5);
    check("post_flush_lat", 64'(lat), 64'd1);

    // Asynchronous reset in the middle of a shift.
    launch(OP_SRA, 32'h8000_0000, 32'd31);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    run_op(OP_SUB, 32'd5, 32'd7, 0, r, c, y, lat);
    check("sub_res", 64'(r), 64'hFFFF_FFFE);
    check("sub_carry", 64'(y), 64'd0);

    for (int n = 0; n < 80; n++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = pick();
      rb = (ro == OP_SLL || ro == OP_SRL || ro == OP_SRA) ? $urandom : pick();
      run_op(ro, ra, rb, $urandom_range(0, 3), r, c, y, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
